// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ALU result path.
//   OPC_*        opcodes whose results write the destination register
//   is_write_op  1 when an opcode's result must be written to rd
//   wb_entry_t   one buffered ALU result {opcode, rd, data}
//   wb_state_e   head-presentation states of the writeback stage
package cpu_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned RegAw = 3;

  localparam logic [3:0] OPC_ADD = 4'b0000;
  localparam logic [3:0] OPC_SUB = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0010;
  localparam logic [3:0] OPC_OR  = 4'b0011;
  localparam logic [3:0] OPC_XOR = 4'b0100;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [RegAw-1:0] rd;
    logic [DataW-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } wb_state_e;

  // Write-class opcodes form the contiguous range OPC_ADD..OPC_XOR.
  function automatic logic is_write_op(input logic [3:0] opcode);
    return (opcode <= OPC_XOR);
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry circular buffer of writeback entries.
//   clk, rst          clock, synchronous active-high reset (drops all entries)
//   push, din         write din at the tail (caller guarantees not full)
//   pop               discard the head (caller guarantees not empty)
//   head, head_valid  oldest entry and whether it exists
//   tail, tail_valid  youngest entry and whether it exists (equals head when count=1)
//   count             occupancy 0..2
module wb_fifo2
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      head_valid,
  output wb_entry_t tail,
  output logic      tail_valid,
  output logic [1:0] count
);

  wb_entry_t  mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head       = mem_q[rd_ptr_q];
  assign tail       = mem_q[~wr_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign tail_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers tagged ALU results and drives the register-file write port.
//   clk, rst                    clock, synchronous active-high reset
//   res_valid/res_ready         result handshake; res_ready = buffer not full
//   res_opcode/res_rd/res_data  incoming result
//   rf_we/rf_waddr/rf_wdata     registered write port, held stable until rf_ready
//   rf_ready                    register file takes the write this cycle
//   fwd_addr/fwd_hit/fwd_data   bypass of the youngest pending write to fwd_addr
//   retired                     results retired (write or no-write), wrapping
// N and RA must match the cpu_pkg entry widths; DEPTH is fixed at 2.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int unsigned N     = DataW,
  parameter int unsigned RA    = RegAw,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [3:0]    res_opcode,
  input  logic [RA-1:0] res_rd,
  input  logic [N-1:0]  res_data,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [N-1:0]  rf_wdata,
  input  logic          rf_ready,
  input  logic [RA-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [N-1:0]  fwd_data,
  output logic [15:0]   retired
);

  wb_state_e     state_q, state_d;
  wb_entry_t     in_entry, head, tail, nxt_entry;
  logic          head_valid, tail_valid, nxt_valid;
  logic [1:0]    count;
  logic          push, pop;
  logic          rf_we_q;
  logic [RA-1:0] rf_waddr_q;
  logic [N-1:0]  rf_wdata_q;
  logic [15:0]   retired_q;

  assign in_entry  = '{opcode: res_opcode, rd: res_rd, data: res_data};
  assign res_ready = (32'(count) < DEPTH);
  assign push      = res_valid & res_ready;
  // rf_we_q is set exactly when a write-class head is presented; other heads leave unconditionally.
  assign pop       = (state_q == StPresent) & (~rf_we_q | rf_ready);

  wb_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .din        (in_entry),
    .head       (head),
    .head_valid (head_valid),
    .tail       (tail),
    .tail_valid (tail_valid),
    .count      (count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Head the buffer will present after this edge, so output regs track it with no bubble:
  // an empty-buffer push lands on rf_we one cycle later, and a pop reloads the next entry at once.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_entry = head;
    if (pop) begin
      if (count == 2'd2) begin
        nxt_valid = 1'b1;
        nxt_entry = tail;
      end else if (push) begin
        nxt_valid = 1'b1;
        nxt_entry = in_entry;
      end
    end else if (head_valid) begin
      nxt_valid = 1'b1;
      nxt_entry = head;
    end else if (push) begin
      nxt_valid = 1'b1;
      nxt_entry = in_entry;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = nxt_valid ? StPresent : StIdle;
  end

  // Output registers: loaded from the presented head; address/data hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= nxt_valid & is_write_op(nxt_entry.opcode);
      if (nxt_valid) begin
        rf_waddr_q <= nxt_entry.rd;
        rf_wdata_q <= nxt_entry.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      retired_q <= 16'd0;
    else if (pop) retired_q <= retired_q + 16'd1;
  end

  // Forwarding: head checked first so a tail match (youngest) overrides it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (head_valid && is_write_op(head.opcode) && (head.rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = head.data;
    end
    if (tail_valid && is_write_op(tail.opcode) && (tail.rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = tail.data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_opcode;
  logic [2:0]  res_rd;
  logic [15:0] res_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_opcode (res_opcode),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_ready   (rf_ready),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .retired    (retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [15:0] d);
    res_valid  = v;
    res_opcode = op;
    res_rd     = rd;
    res_data   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", rf_we); end
    n_tests++; if (rf_waddr !== 3'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
    n_tests++; if (rf_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0000", rf_wdata); end
    n_tests++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", res_ready); end
    n_tests++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit got %b want 0", fwd_hit); end
    n_tests++; if (fwd_data !== 16'h0) begin n_fail++; $display("FAIL reset_fwd_data got %h want 0000", fwd_data); end
    n_tests++; if (retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
  endtask

  task automatic test_write();
    rf_ready = 1'b1;
    drive(1'b1, 4'b0000, 3'd3, 16'h1234);
    step();
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL write_we got %b want 1", rf_we); end
    n_tests++; if (rf_waddr !== 3'd3) begin n_fail++; $display("FAIL write_waddr got %0d want 3", rf_waddr); end
    n_tests++; if (rf_wdata !== 16'h1234) begin n_fail++; $display("FAIL write_wdata got %h want 1234", rf_wdata); end
    step();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL write_we_drop got %b want 0", rf_we); end
    n_tests++; if (retired !== 16'd1) begin n_fail++; $display("FAIL write_retired got %0d want 1", retired); end
  endtask

  task automatic test_nowrite();
    drive(1'b1, 4'b0111, 3'd2, 16'hBEEF);
    step();
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    fwd_addr = 3'd2;
    #1;
    n_tests++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL nowrite_fwd got %b want 0", fwd_hit); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_we got %b want 0", rf_we); end
    step();
    n_tests++; if (retired !== 16'd2) begin n_fail++; $display("FAIL nowrite_retired got %0d want 2", retired); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_we_after got %b want 0", rf_we); end
  endtask

  task automatic test_stall();
    rf_ready = 1'b0;
    drive(1'b1, 4'b0001, 3'd1, 16'h1111);
    step();
    drive(1'b1, 4'b0010, 3'd2, 16'h2222);
    step();
    n_tests++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got %b want 0", res_ready); end
    drive(1'b1, 4'b0011, 3'd4, 16'h4444);
    step();
    n_tests++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_hold got %b want 0", res_ready); end
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL stall_we got %b want 1", rf_we); end
    n_tests++; if (rf_waddr !== 3'd1) begin n_fail++; $display("FAIL stall_waddr got %0d want 1", rf_waddr); end
    n_tests++; if (rf_wdata !== 16'h1111) begin n_fail++; $display("FAIL stall_wdata got %h want 1111", rf_wdata); end
    rf_ready = 1'b1;
    step();
    n_tests++; if (rf_wdata !== 16'h2222) begin n_fail++; $display("FAIL stall_second got %h want 2222", rf_wdata); end
    n_tests++; if (rf_waddr !== 3'd2) begin n_fail++; $display("FAIL stall_second_addr got %0d want 2", rf_waddr); end
    n_tests++; if (retired !== 16'd3) begin n_fail++; $display("FAIL stall_retired3 got %0d want 3", retired); end
    step();
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    n_tests++; if (rf_wdata !== 16'h4444) begin n_fail++; $display("FAIL stall_third got %h want 4444", rf_wdata); end
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL stall_third_we got %b want 1", rf_we); end
    n_tests++; if (retired !== 16'd4) begin n_fail++; $display("FAIL stall_retired4 got %0d want 4", retired); end
    step();
    n_tests++; if (retired !== 16'd5) begin n_fail++; $display("FAIL stall_retired5 got %0d want 5", retired); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stall_drain_we got %b want 0", rf_we); end
  endtask

  task automatic test_full_pop();
    rf_ready = 1'b0;
    drive(1'b1, 4'b0000, 3'd1, 16'hAAAA);
    step();
    drive(1'b1, 4'b0100, 3'd2, 16'hBBBB);
    step();
    drive(1'b1, 4'b0000, 3'd3, 16'hCCCC);
    #1;
    n_tests++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", res_ready); end
    rf_ready = 1'b1;
    step();
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    n_tests++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL full_count1 got %b want 1", res_ready); end
    n_tests++; if (rf_wdata !== 16'hBBBB) begin n_fail++; $display("FAIL full_next got %h want bbbb", rf_wdata); end
    n_tests++; if (retired !== 16'd6) begin n_fail++; $display("FAIL full_retired got %0d want 6", retired); end
    step();
    fwd_addr = 3'd3;
    #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_dropped_we got %b want 0", rf_we); end
    n_tests++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL full_dropped_fwd got %b want 0", fwd_hit); end
    n_tests++; if (retired !== 16'd7) begin n_fail++; $display("FAIL full_retired2 got %0d want 7", retired); end
  endtask

  task automatic test_forward_and_reset();
    rf_ready = 1'b0;
    drive(1'b1, 4'b0000, 3'd5, 16'h0001);
    step();
    drive(1'b1, 4'b0001, 3'd5, 16'h0002);
    step();
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    fwd_addr = 3'd5;
    #1;
    n_tests++; if (fwd_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got %b want 1", fwd_hit); end
    n_tests++; if (fwd_data !== 16'h0002) begin n_fail++; $display("FAIL fwd_youngest got %h want 0002", fwd_data); end
    n_tests++; if (rf_wdata !== 16'h0001) begin n_fail++; $display("FAIL fwd_head_wdata got %h want 0001", rf_wdata); end
    fwd_addr = 3'd6;
    #1;
    n_tests++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got %b want 0", fwd_hit); end
    fwd_addr = 3'd5;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b want 0", rf_we); end
    n_tests++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", res_ready); end
    n_tests++; if (retired !== 16'd0) begin n_fail++; $display("FAIL midrst_retired got %0d want 0", retired); end
    n_tests++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL midrst_fwd got %b want 0", fwd_hit); end
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write[%0d] got %b want 0", i, rf_we); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    rf_ready  = 1'b0;
    fwd_addr  = 3'd0;
    drive(1'b0, 4'b0000, 3'd0, 16'h0);
    test_reset();
    test_write();
    test_nowrite();
    test_stall();
    test_full_pop();
    test_forward_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
